// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared encodings for the multicycle RV32I control path
// (states, ALU operation codes, opcodes and datapath mux selects).
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct fields to the ALU control code;
// shared with the pipelined control unit.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      if (alu_op == ALUOP_SUB)
         alu_control = ALU_SUB;
      else if (alu_op == ALUOP_FUNCT)
         case (funct3)
            3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
         endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-memory, shared-ALU RV32I
// datapath through fetch/decode/execute/memory/writeback with a memory-ready stall.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   state_t  state_q, state_d;
   alu_op_t alu_op;
   logic    pc_w, mem_w, ir_w, reg_w, done, ill;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;

   always_comb begin
      state_d    = state_q;
      pc_w       = 1'b0;
      adr_src    = 1'b0;
      mem_w      = 1'b0;
      ir_w       = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      reg_w      = 1'b0;
      done       = 1'b0;
      ill        = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_w       = mem_ready;
            pc_w       = mem_ready;
            state_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  ill     = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            done       = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            done    = mem_ready;
            state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w   = 1'b1;
            done    = 1'b1;
            state_d = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_w      = zero;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_w      = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase

   alu_decoder u_alu_decoder (
      .alu_op     (alu_op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alu_control(alu_control)
   );

   // Reset must suppress every side effect even though FETCH would otherwise assert loads.
   assign pc_write   = pc_w  & rst;
   assign mem_write  = mem_w & rst;
   assign ir_write   = ir_w  & rst;
   assign reg_write  = reg_w & rst;
   assign instr_done = done  & rst;
   assign illegal    = ill   & rst;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle expected control words are queued as stimulus
// is driven and compared against the DUT outputs on the following falling edge.
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] imm_src;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   string cur_tag = "reset";
   logic [1:0] cur_imm = 2'b00;
   logic cur_ill = 1'b0;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_src(imm_src), .reg_write(reg_write), .instr_done(instr_done),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input int st, input logic mr, input logic z, input logic [2:0] ac);
      exp_t e = '0;
      e.state       = st[3:0];
      e.imm_src     = cur_imm;
      e.alu_control = ac;
      case (st)
         0: begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr; end
         1: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.illegal = cur_ill; end
         2: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
         3: e.adr_src = 1'b1;
         4: begin e.result_src = 2'b01; e.reg_write = 1'b1; e.instr_done = 1'b1; end
         5: begin e.adr_src = 1'b1; e.mem_write = 1'b1; e.instr_done = mr; end
         6: e.alu_src_a = 2'b10;
         7: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
         8: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
         9: begin e.alu_src_a = 2'b10; e.pc_write = z; e.instr_done = 1'b1; end
         10: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
         default: ;
      endcase
      if (!rst) begin
         e.pc_write = 0; e.ir_write = 0; e.reg_write = 0;
         e.mem_write = 0; e.instr_done = 0; e.illegal = 0;
      end
      return e;
   endfunction

   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e, a;
         e = sb.pop_front();
         a = {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal};
         check($sformatf("%s st%0d", cur_tag, e.state), 32'(a), 32'(e));
      end

   task automatic load(input string tag, input logic [31:0] ins, input logic [1:0] imm, input logic ill);
      cur_tag  = tag;
      op       = ins[6:0];
      funct3   = ins[14:12];
      funct7b5 = ins[30];
      cur_imm  = imm;
      cur_ill  = ill;
   endtask

   task automatic cyc(input int st, input logic mr, input logic z, input logic [2:0] ac);
      mem_ready = mr;
      zero      = z;
      sb.push_back(model(st, mr, z, ac));
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      cyc(0, 1, 0, 3'b000);
      cyc(0, 1, 0, 3'b000);
      rst = 1'b1;
      load("lw", 32'h00412283, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(2, 1, 0, 3'b000);
      cyc(3, 1, 0, 3'b000); cyc(4, 1, 0, 3'b000);
      load("lw_stall", 32'h00412283, 2'b00, 0);
      cyc(0, 0, 0, 3'b000); cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000);
      cyc(2, 1, 0, 3'b000); cyc(3, 0, 0, 3'b000); cyc(3, 1, 0, 3'b000); cyc(4, 1, 0, 3'b000);
      load("sw", 32'h00512223, 2'b01, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(2, 1, 0, 3'b000);
      cyc(5, 0, 0, 3'b000); cyc(5, 0, 0, 3'b000); cyc(5, 1, 0, 3'b000);
      load("sub", 32'h40208033, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(6, 1, 0, 3'b001); cyc(8, 1, 0, 3'b000);
      load("or", 32'h0020E033, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(6, 1, 0, 3'b011); cyc(8, 1, 0, 3'b000);
      load("slt", 32'h0020A033, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(6, 1, 0, 3'b101); cyc(8, 1, 0, 3'b000);
      load("and", 32'h0020F033, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(6, 1, 0, 3'b010); cyc(8, 1, 0, 3'b000);
      load("addi_f7", 32'h40000093, 2'b00, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(7, 1, 0, 3'b000); cyc(8, 1, 0, 3'b000);
      load("beq_taken", 32'h00208463, 2'b10, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(9, 1, 1, 3'b001);
      load("beq_not", 32'h00208463, 2'b10, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(9, 1, 0, 3'b001);
      load("jal", 32'h008000EF, 2'b11, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(10, 1, 0, 3'b000); cyc(8, 1, 0, 3'b000);
      load("illegal", 32'h0000007F, 2'b00, 1);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000);
      load("sw_abort", 32'h00512223, 2'b01, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(2, 1, 0, 3'b000);
      mem_ready = 1'b0;
      #1 check("abort mem_write before", 32'(mem_write), 32'd1);
      rst = 1'b0;
      #1 check("abort mem_write", 32'(mem_write), 32'd0);
      check("abort state", 32'(state), 32'd0);
      check("abort ir_write", 32'(ir_write), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      load("restart_jal", 32'h008000EF, 2'b11, 0);
      cyc(0, 1, 0, 3'b000); cyc(1, 1, 0, 3'b000); cyc(10, 1, 0, 3'b000); cyc(8, 1, 0, 3'b000);
      cyc(0, 1, 0, 3'b000);
      @(negedge clk);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller that turns the single-cycle RV32I datapath into a multicycle machine sharing one memory port and one ALU across instruction phases. Moore FSM walks each instruction through fetch, decode, execute, memory and writeback, driving the datapath's mux selects, write enables and ALU operation every cycle. Sits beside the datapath top and replaces the combinational control unit. A memory-ready handshake stretches the memory phases.

## Interface
- No parameters. Encodings (state, ALU op, opcodes) come from shared constants.
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- op  in  7  instruction opcode, from the instruction register, bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag (current-cycle ALU result == 0)
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register and OldPC load
- result_src  out  2  00 = ALUOut, 01 = memory data register, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type
- reg_write  out  1  register file write
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug

## Operation
- States (4-bit encoding) and their active outputs:
  - FETCH=0: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp add, result_src=10. ir_write and pc_write assert only when mem_ready=1.
  - DECODE=1: alu_src_a=01, alu_src_b=01, ALUOp add. Computes the branch target into ALUOut.
  - MEMADR=2: alu_src_a=10, alu_src_b=01, ALUOp add.
  - MEMREAD=3: adr_src=1, result_src=00.
  - MEMWB=4: result_src=01, reg_write=1.
  - MEMWRITE=5: adr_src=1, result_src=00, mem_write=1.
  - EXECUTER=6: alu_src_a=10, alu_src_b=00, ALUOp funct.
  - EXECUTEI=7: alu_src_a=10, alu_src_b=01, ALUOp funct.
  - ALUWB=8: result_src=00, reg_write=1.
  - BEQ=9: alu_src_a=10, alu_src_b=00, ALUOp sub, result_src=00. pc_write = zero.
  - JAL=10: alu_src_a=01, alu_src_b=10, ALUOp add, result_src=00, pc_write=1.
- Transitions:
  - FETCH to DECODE when mem_ready, else stay in FETCH.
  - DECODE goes by opcode:
    - 0000011 (lw) or 0100011 (sw) to MEMADR.
    - 0110011 (R-type) to EXECUTER.
    - 0010011 (I-type ALU) to EXECUTEI.
    - 1100011 (beq) to BEQ.
    - 1101111 (jal) to JAL.
    - Any other opcode to FETCH, with illegal=1.
  - MEMADR to MEMREAD for lw, to MEMWRITE for sw.
  - MEMREAD to MEMWB when mem_ready, else stay.
  - MEMWRITE to FETCH when mem_ready, else stay; mem_write held high while waiting.
  - EXECUTER and EXECUTEI to ALUWB. JAL to ALUWB.
  - MEMWB, ALUWB and BEQ to FETCH.
- ALU decoder:
  - ALUOp add gives 000; ALUOp sub gives 001.
  - ALUOp funct decodes funct3:
    - 000: sub if op[5] & funct7b5, else add.
    - 010: slt. 110: or. 111: and.
    - Any other funct3: add.
- imm_src is combinational from op, all states:
  - lw or I-type ALU: 00. sw: 01. beq: 10. jal: 11.
  - Any other opcode: 00.
- instr_done pulses in MEMWB, ALUWB and BEQ, and in MEMWRITE on its mem_ready cycle.
- All non-listed outputs are 0 in every state.

## Timing
- Reset: state=FETCH. pc_write, ir_write, reg_write, mem_write, instr_done and illegal are forced to 0 while rst=0, regardless of mem_ready.
- Outputs are combinational from state plus zero/mem_ready/op. The state register is the only flop.
- Cycles per instruction with mem_ready held at 1:
  - lw 5
  - sw 4
  - R-type, I-type ALU and jal 4
  - beq 3
  - illegal opcode 2
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No timeout.
- Reset asserted mid-instruction aborts it immediately: no partial write may occur after rst falls. Restart is in FETCH on the first clock edge after rst rises.
- The opcode is sampled only in DECODE and MEMADR. The instruction register is stable there because ir_write=0.

## Structure
- The shared header holds:
  - state encodings,
  - alu_control codes,
  - ALUOp codes (add, sub, funct),
  - opcode constants,
  - result_src, alu_src_a and alu_src_b codes.
- One sub-module, alu_decoder: combinational (ALUOp, funct3, funct7b5, op[5]) to alu_control. It is reused by a future pipelined control unit.

## Test plan
- Reset: hold rst=0 with mem_ready=1 → state=0 and all enables 0. Release → ir_write=1 and pc_write=1 on the first FETCH cycle.
- lw 0x00412283 (op 0000011), mem_ready=1 → states 0,1,2,3,4; reg_write=1 only in state 4; result_src=01; imm_src=00; instr_done on cycle 5.
- sw 0x00512223, mem_ready low for 2 cycles in MEMWRITE → mem_write high for 3 cycles, then FETCH; imm_src=01; total 6 cycles.
- R-type sub 0x40208033 → alu_control=001 in EXECUTER. R-type or (funct3=110) → 011. addi with funct7b5=1 → 000, not sub.
- beq 0x00208463: zero=1 → pc_write=1 in BEQ, alu_control=001, imm_src=10. zero=0 → pc_write=0. Either way FETCH follows after 3 cycles.
- jal 0x008000EF → states 0,1,10,8 with pc_write=1 in JAL and reg_write=1 in ALUWB. Opcode 0x7F → illegal pulse in DECODE, then FETCH. rst dropped in MEMWRITE → mem_write falls asynchronously.
